// File: rtl/store_buffer_if.sv
// Bundle of the memory-queue request/response signals and the dcache port
// seen by the store buffer.
interface store_buffer_if;
  logic [31:0] d_addr;
  logic [3:0]  d_rmask;
  logic [3:0]  d_wmask;
  logic [31:0] d_wdata;
  logic [31:0] sb_data_in;
  logic        sb_data_valid;
  logic        sb_store_resp;
  logic        sb_full;
  logic [31:0] dc_addr;
  logic [3:0]  dc_rmask;
  logic [3:0]  dc_wmask;
  logic [31:0] dc_wdata;
  logic [31:0] dc_rdata;
  logic        dc_resp;

  modport slave (
    input  d_addr, d_rmask, d_wmask, d_wdata, dc_rdata, dc_resp,
    output sb_data_in, sb_data_valid, sb_store_resp, sb_full,
           dc_addr, dc_rmask, dc_wmask, dc_wdata
  );

  modport master (
    output d_addr, d_rmask, d_wmask, d_wdata, dc_rdata, dc_resp,
    input  sb_data_in, sb_data_valid, sb_store_resp, sb_full,
           dc_addr, dc_rmask, dc_wmask, dc_wdata
  );
endinterface

// File: rtl/store_buffer.sv
// Committed-store FIFO with store-to-load forwarding and background drain to
// the dcache; loads win over drain only when the dcache port is idle.
module store_buffer #(
  parameter int SB_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  store_buffer_if.slave bus
);
  localparam int AW = $clog2(SB_DEPTH);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]                  state;
  logic [SB_DEPTH-1:0][31:0]   addr_q;
  logic [SB_DEPTH-1:0][31:0]   wdata_q;
  logic [SB_DEPTH-1:0][3:0]    wmask_q;
  logic [AW:0]                 head, tail, count;
  logic [AW-1:0]               head_idx, tail_idx;

  logic        pend_vld;
  logic [31:0] pend_addr;
  logic [3:0]  pend_rmask;
  logic        store_resp_q, data_vld_q;
  logic [31:0] data_q;

  logic        req_ld, req_st, cur_vld;
  logic [31:0] cur_addr;
  logic [3:0]  cur_rmask;
  logic        hit, covered, fwd, eligible;
  logic [AW-1:0] hit_idx, scan_idx;
  logic [31:0] lane_mask;

  assign head_idx = head[AW-1:0];
  assign tail_idx = tail[AW-1:0];
  assign count    = tail - head;

  assign req_ld = |bus.d_rmask;
  assign req_st = |bus.d_wmask;

  // A fresh load is searched in its request cycle so a forward can answer
  // one cycle later; a blocked load keeps re-searching from the pending copy.
  assign cur_vld   = pend_vld | req_ld;
  assign cur_addr  = pend_vld ? pend_addr  : bus.d_addr;
  assign cur_rmask = pend_vld ? pend_rmask : bus.d_rmask;

  // Scan oldest to youngest so the last match found is the youngest.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      scan_idx = head_idx + AW'(k);
      if (((AW+1)'(k) < count) && (addr_q[scan_idx] == cur_addr)) begin
        hit     = 1'b1;
        hit_idx = scan_idx;
      end
    end
  end

  generate
    for (genvar b = 0; b < 4; b++) begin : g_lane
      assign lane_mask[8*b +: 8] = {8{wmask_q[hit_idx][b]}};
    end
  endgenerate

  assign covered  = (wmask_q[hit_idx] & cur_rmask) == cur_rmask;
  assign fwd      = req_ld && !pend_vld && hit && covered;
  assign eligible = cur_vld && !hit;

  always_ff @(posedge clk) begin
    if (req_st) begin
      addr_q[tail_idx]  <= bus.d_addr;
      wmask_q[tail_idx] <= bus.d_wmask;
      wdata_q[tail_idx] <= bus.d_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      head         <= '0;
      tail         <= '0;
      pend_vld     <= 1'b0;
      pend_addr    <= '0;
      pend_rmask   <= '0;
      store_resp_q <= 1'b0;
      data_vld_q   <= 1'b0;
      data_q       <= '0;
    end else begin
      store_resp_q <= req_st;
      data_vld_q   <= 1'b0;
      if (req_st) tail <= tail + (AW+1)'(1);
      if (req_ld && !fwd) begin
        pend_vld   <= 1'b1;
        pend_addr  <= bus.d_addr;
        pend_rmask <= bus.d_rmask;
      end
      if (fwd) begin
        data_vld_q <= 1'b1;
        data_q     <= wdata_q[hit_idx] & lane_mask;
      end
      case (state)
        IDLE: begin
          if (eligible)          state <= LOAD;
          else if (count != '0)  state <= DRAIN;
        end
        LOAD: if (bus.dc_resp) begin
          data_vld_q <= 1'b1;
          data_q     <= bus.dc_rdata;
          pend_vld   <= 1'b0;
          state      <= IDLE;
        end
        DRAIN: if (bus.dc_resp) begin
          head  <= head + (AW+1)'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.dc_addr  = '0;
    bus.dc_rmask = '0;
    bus.dc_wmask = '0;
    bus.dc_wdata = '0;
    case (state)
      LOAD: begin
        bus.dc_addr  = pend_addr;
        bus.dc_rmask = pend_rmask;
      end
      DRAIN: begin
        bus.dc_addr  = addr_q[head_idx];
        bus.dc_wmask = wmask_q[head_idx];
        bus.dc_wdata = wdata_q[head_idx];
      end
      default: ;
    endcase
  end

  assign bus.sb_store_resp = store_resp_q;
  assign bus.sb_data_valid = data_vld_q;
  assign bus.sb_data_in    = data_vld_q ? data_q : '0;
  assign bus.sb_full       = (head_idx == tail_idx) && (head[AW] != tail[AW]);
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: store accept/drain, fill and wrap,
// forwarding, blocked partial loads, reset mid-drain, enqueue with pop.
module tb_store_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  store_buffer_if bus();

  store_buffer #(.SB_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    bus.d_addr = a; bus.d_wmask = m; bus.d_wdata = d;
    tick();
    bus.d_addr = '0; bus.d_wmask = '0; bus.d_wdata = '0;
    check("store_resp", {31'd0, bus.sb_store_resp}, 32'd1);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [3:0] m);
    bus.d_addr = a; bus.d_rmask = m;
    tick();
    bus.d_addr = '0; bus.d_rmask = '0;
  endtask

  // Waits (bounded) for a dcache write, checks it, then answers it.
  task automatic drain_one(input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    while (bus.dc_wmask == 4'd0 && n < 10) begin
      tick();
      n++;
    end
    check("drain_seen", {31'd0, bus.dc_wmask != 4'd0}, 32'd1);
    check("drain_addr", bus.dc_addr, a);
    check("drain_data", bus.dc_wdata, d);
    bus.dc_resp = 1'b1;
    tick();
    bus.dc_resp = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bus.d_addr = '0; bus.d_rmask = '0; bus.d_wmask = '0; bus.d_wdata = '0;
    bus.dc_rdata = '0; bus.dc_resp = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_full", {31'd0, bus.sb_full}, 32'd0);
    check("rst_valid", {31'd0, bus.sb_data_valid}, 32'd0);
    check("rst_sresp", {31'd0, bus.sb_store_resp}, 32'd0);
    check("rst_dc_addr", bus.dc_addr, 32'd0);
    check("rst_dc_wmask", {28'd0, bus.dc_wmask}, 32'd0);
    check("rst_dc_rmask", {28'd0, bus.dc_rmask}, 32'd0);

    // single store, one-cycle ack, drained from IDLE
    do_store(32'h1000, 4'hF, 32'hDEADBEEF);
    check("st1_dc_idle", {28'd0, bus.dc_wmask}, 32'd0);
    tick();
    check("st1_resp_low", {31'd0, bus.sb_store_resp}, 32'd0);
    check("st1_dc_wmask", {28'd0, bus.dc_wmask}, 32'hF);
    tick();
    check("st1_dc_hold", bus.dc_addr, 32'h1000);
    drain_one(32'h1000, 32'hDEADBEEF);
    tick();
    check("st1_empty", {28'd0, bus.dc_wmask}, 32'd0);

    // fill to full, pop once, fifth store wraps the tail
    for (int i = 0; i < 4; i++) begin
      do_store(32'h100 + 32'(4 * i), 4'hF, 32'(i + 1));
      check("fill_full", {31'd0, bus.sb_full}, (i == 3) ? 32'd1 : 32'd0);
    end
    bus.dc_resp = 1'b1;
    tick();
    bus.dc_resp = 1'b0;
    check("pop_unfull", {31'd0, bus.sb_full}, 32'd0);
    do_store(32'h110, 4'hF, 32'd5);
    check("wrap_full", {31'd0, bus.sb_full}, 32'd1);
    drain_one(32'h104, 32'd2);
    drain_one(32'h108, 32'd3);
    drain_one(32'h10C, 32'd4);
    drain_one(32'h110, 32'd5);
    tick(); tick();
    check("wrap_empty", {28'd0, bus.dc_wmask}, 32'd0);

    // fully covered load forwards next cycle without a dcache read
    do_store(32'h2000, 4'hF, 32'h11223344);
    do_load(32'h2000, 4'hF);
    check("fwd_valid", {31'd0, bus.sb_data_valid}, 32'd1);
    check("fwd_data", bus.sb_data_in, 32'h11223344);
    check("fwd_no_read", {28'd0, bus.dc_rmask}, 32'd0);
    drain_one(32'h2000, 32'h11223344);
    check("fwd_valid_low", {31'd0, bus.sb_data_valid}, 32'd0);

    // partial coverage blocks the load until the entry drains
    do_store(32'h3000, 4'h1, 32'h000000AB);
    do_load(32'h3000, 4'hF);
    check("blk_valid", {31'd0, bus.sb_data_valid}, 32'd0);
    check("blk_drain", {28'd0, bus.dc_wmask}, 32'h1);
    check("blk_no_read", {28'd0, bus.dc_rmask}, 32'd0);
    tick();
    check("blk_still", {31'd0, bus.sb_data_valid}, 32'd0);
    bus.dc_resp = 1'b1;
    tick();
    bus.dc_resp = 1'b0;
    check("blk_idle", {28'd0, bus.dc_rmask}, 32'd0);
    tick();
    check("blk_rmask", {28'd0, bus.dc_rmask}, 32'hF);
    check("blk_raddr", bus.dc_addr, 32'h3000);
    check("blk_no_wr", {28'd0, bus.dc_wmask}, 32'd0);
    bus.dc_resp = 1'b1; bus.dc_rdata = 32'h555555AB;
    tick();
    bus.dc_resp = 1'b0; bus.dc_rdata = '0;
    check("blk_valid2", {31'd0, bus.sb_data_valid}, 32'd1);
    check("blk_data", bus.sb_data_in, 32'h555555AB);
    check("blk_rd_done", {28'd0, bus.dc_rmask}, 32'd0);
    tick();
    check("blk_pulse", {31'd0, bus.sb_data_valid}, 32'd0);

    // youngest of two matching entries wins
    do_store(32'h4000, 4'hF, 32'h1);
    do_store(32'h4000, 4'hF, 32'h2);
    do_load(32'h4000, 4'hF);
    check("young_valid", {31'd0, bus.sb_data_valid}, 32'd1);
    check("young_data", bus.sb_data_in, 32'h2);
    drain_one(32'h4000, 32'h1);
    drain_one(32'h4000, 32'h2);

    // reset mid-drain discards buffered stores
    do_store(32'h500, 4'hF, 32'hA);
    do_store(32'h504, 4'hF, 32'hB);
    do_store(32'h508, 4'hF, 32'hC);
    check("pre_rst_drain", {28'd0, bus.dc_wmask}, 32'hF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_wmask", {28'd0, bus.dc_wmask}, 32'd0);
    check("mid_rst_addr", bus.dc_addr, 32'd0);
    check("mid_rst_full", {31'd0, bus.sb_full}, 32'd0);
    check("mid_rst_sresp", {31'd0, bus.sb_store_resp}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_quiet", {28'd0, bus.dc_wmask}, 32'd0);
    end

    // enqueue and pop in the same cycle leaves occupancy unchanged
    do_store(32'h600, 4'hF, 32'h60);
    do_store(32'h604, 4'hF, 32'h64);
    do_store(32'h608, 4'hF, 32'h68);
    bus.d_addr = 32'h60C; bus.d_wmask = 4'hF; bus.d_wdata = 32'h6C; bus.dc_resp = 1'b1;
    tick();
    bus.d_addr = '0; bus.d_wmask = '0; bus.d_wdata = '0; bus.dc_resp = 1'b0;
    check("enq_pop_resp", {31'd0, bus.sb_store_resp}, 32'd1);
    check("enq_pop_full", {31'd0, bus.sb_full}, 32'd0);
    drain_one(32'h604, 32'h64);
    drain_one(32'h608, 32'h68);
    drain_one(32'h60C, 32'h6C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
